// File: rtl/mem_responder.sv
// mem_responder: fixed-latency 32-bit word RAM responder for the fetch/store bus.
// Define MEM_WRITE_PROTECT_EN to reject writes to words below RO_WORDS (reported on werr).
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int RO_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       data,
  output logic              werr
);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];
  logic              accept, fin, prot;
  always_comb begin
    accept  = state == IDLE && Valid;
    fin     = state == BUSY && cnt == '0;
    prot    = WP && !rw_q && 32'(addr_q) < $unsigned(RO_WORDS);
    state_n = accept ? BUSY : fin ? DONE : (state == DONE && !Valid) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ready   <= 1'b1;
      data    <= '0;
      werr    <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr;
      rw_q    <= RW;
      wdata_q <= wdata;
      ready   <= 1'b0;
      cnt     <= CW'(LATENCY - 1);
      werr    <= 1'b0;
    end else if (fin) begin
      ready <= 1'b1;
      werr  <= prot;
      if (rw_q) data <= mem[addr_q];
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
    end
  end
  // array has no reset; a reset mid-BUSY leaves state IDLE so the pending write never fires
  always_ff @(posedge clk)
    if (fin && !rw_q && !prot) mem[addr_q] <= wdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, hand-written corner sequences and a random run
// against a word-array reference model for mem_responder.
module tb_mem_responder;
  localparam int L  = 2;
  localparam int RO = 16;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, Valid, RW;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready, werr;
  logic [31:0] data;
  logic        v1, rw1;
  logic [7:0]  a1;
  logic [31:0] wd1;
  logic        rdy1, we1;
  logic [31:0] d1;
  int n = 0, nf = 0;
  logic [31:0] mm [256];
  bit          known [256];
  logic [31:0] md;
  typedef struct {
    bit          rw;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] ed;
    bit          ew;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DEPTH(256), .LATENCY(L), .RO_WORDS(RO)) u0 (
    .clk(clk), .reset(reset), .Valid(Valid), .RW(RW), .addr(addr), .wdata(wdata),
    .ready(ready), .data(data), .werr(werr));
  mem_responder #(.ADDR_W(8), .DEPTH(256), .LATENCY(1), .RO_WORDS(0)) u1 (
    .clk(clk), .reset(reset), .Valid(v1), .RW(rw1), .addr(a1), .wdata(wd1),
    .ready(rdy1), .data(d1), .werr(we1));

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Full request handshake on u0: wait for ready to fall then rise, optionally hold Valid, then release.
  task automatic txn(input bit rw, input logic [7:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] d, output logic w, output int low, output logic first, output int relow);
    Valid = 1'b1; RW = rw; addr = a; wdata = wd;
    low = 0; relow = 0; first = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) first = ready;
      if (!ready) low++;
      else if (low > 0) break;
    end
    d = data; w = werr;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!ready) relow++;
    end
    Valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic txn1(input bit rw, input logic [7:0] a, input logic [31:0] wd, output logic [31:0] d, output int low);
    v1 = 1'b1; rw1 = rw; a1 = a; wd1 = wd; low = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!rdy1) low++;
      else if (low > 0) break;
    end
    d = d1;
    v1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_apply(input bit rw, input logic [7:0] a, input logic [31:0] wd,
                             output logic [31:0] ed, output bit ew);
    ew = WP && !rw && int'(a) < RO;
    if (rw) md = mm[a];
    else if (!ew) begin
      mm[a] = wd;
      known[a] = 1'b1;
    end
    ed = md;
  endtask

  initial begin
    logic [31:0] d, ed, d0;
    logic w, first;
    bit ew, rw;
    logic [7:0] a;
    logic [31:0] wd;
    int low, relow;
    tbl[0] = '{1'b0, 8'h20, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 8'h20, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 8'h10, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b0, 8'hFF, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[5] = '{1'b1, 8'h10, 32'h0,        32'h12345678, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 32'h0,        32'h12345678, 1'b0};
    tbl[7] = '{1'b1, 8'h80, 32'h0,        32'h0,        1'b0};
    tbl[8] = '{1'b0, 8'h20, 32'h11111111, 32'h0,        1'b0};
    tbl[9] = '{1'b1, 8'h20, 32'h0,        32'h11111111, 1'b0};
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    md = '0;
    reset = 1'b0; Valid = 1'b0; RW = 1'b0; addr = '0; wdata = '0;
    v1 = 1'b0; rw1 = 1'b0; a1 = '0; wd1 = '0;
    @(posedge clk); #1;
    chk("rst_ready", 0, 32'(ready), 32'd1);
    chk("rst_data", 0, data, 32'h0);
    chk("rst_werr", 0, 32'(werr), 32'd0);
    chk("rst_ready_l1", 0, 32'(rdy1), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      model_apply(tbl[i].rw, tbl[i].a, tbl[i].wd, ed, ew);
      txn(tbl[i].rw, tbl[i].a, tbl[i].wd, 0, d, w, low, first, relow);
      chk("tbl_data", i, d, tbl[i].ed);
      chk("tbl_werr", i, 32'(w), 32'(tbl[i].ew));
      chk("tbl_low", i, 32'(low), 32'(L));
      chk("tbl_first_low", i, 32'(first), 32'd0);
    end

    for (int i = 0; i < 120; i++) begin
      rw = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 40));
      wd = $urandom;
      if (rw && !known[a]) rw = 1'b0;
      model_apply(rw, a, wd, ed, ew);
      txn(rw, a, wd, 0, d, w, low, first, relow);
      chk("rnd_data", i, d, ed);
      chk("rnd_werr", i, 32'(w), 32'(ew));
      chk("rnd_low", i, 32'(low), 32'(L));
    end

    txn(1'b0, 8'h10, 32'h12345678, 0, d, w, low, first, relow);
    txn(1'b0, 8'h40, 32'hAAAA5555, 0, d, w, low, first, relow);
    // Valid held through DONE: no second busy pulse, then IDLE right after release
    txn(1'b1, 8'h40, 32'h0, 6, d, w, low, first, relow);
    chk("held_data", 0, d, 32'hAAAA5555);
    chk("held_relow", 0, 32'(relow), 32'd0);
    txn(1'b1, 8'h10, 32'h0, 0, d, w, low, first, relow);
    chk("held_reaccept", 0, 32'(first), 32'd0);
    chk("held_next_data", 0, d, 32'h12345678);

    // Early withdraw with live fields changed during BUSY
    Valid = 1'b1; RW = 1'b1; addr = 8'h10;
    @(posedge clk); #1;
    chk("ew_accept", 0, 32'(ready), 32'd0);
    Valid = 1'b0; addr = 8'h05; RW = 1'b0; wdata = 32'hBAD0BAD0;
    low = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ready) break;
      low++;
    end
    chk("ew_low", 0, 32'(low), 32'(L));
    chk("ew_data", 0, data, 32'h12345678);
    @(posedge clk); #1;
    txn(1'b1, 8'h10, 32'h0, 0, d, w, low, first, relow);
    chk("ew_idle", 0, 32'(first), 32'd0);
    chk("ew_reread", 0, d, 32'h12345678);

    // Protected region (werr only when the macro is enabled)
    txn(1'b1, 8'h03, 32'h0, 0, d0, w, low, first, relow);
    txn(1'b0, 8'h03, 32'h1, 0, d, w, low, first, relow);
    chk("wp_werr3", 0, 32'(w), 32'(WP));
    chk("wp_low3", 0, 32'(low), 32'(L));
    txn(1'b1, 8'h03, 32'h0, 0, d, w, low, first, relow);
    chk("wp_read3", 0, d, WP ? d0 : 32'h1);
    chk("wp_werr_clr", 0, 32'(w), 32'd0);
    txn(1'b0, 8'h10 + 8'h00 + 8'h00, 32'h0, 0, d, w, low, first, relow);
    txn(1'b0, 8'd16, 32'h16161616, 0, d, w, low, first, relow);
    chk("wp_werr16", 0, 32'(w), 32'd0);
    txn(1'b1, 8'd16, 32'h0, 0, d, w, low, first, relow);
    chk("wp_read16", 0, d, 32'h16161616);

    // LATENCY=1 instance: extreme addresses
    txn1(1'b0, 8'h00, 32'h0BADF00D, d, low);
    txn1(1'b0, 8'hFF, 32'h600DCAFE, d, low);
    txn1(1'b1, 8'h00, 32'h0, d, low);
    chk("l1_data0", 0, d, 32'h0BADF00D);
    chk("l1_low0", 0, 32'(low), 32'd1);
    txn1(1'b1, 8'hFF, 32'h0, d, low);
    chk("l1_dataff", 0, d, 32'h600DCAFE);
    chk("l1_lowff", 0, 32'(low), 32'd1);

    // Reset mid-BUSY discards the pending write
    txn(1'b1, 8'h40, 32'h0, 0, d, w, low, first, relow);
    Valid = 1'b1; RW = 1'b0; addr = 8'h40; wdata = 32'hBBBBBBBB;
    @(posedge clk); #1;
    chk("mid_busy", 0, 32'(ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 0, 32'(ready), 32'd1);
    chk("mid_rst_data", 0, data, 32'h0);
    chk("mid_rst_werr", 0, 32'(werr), 32'd0);
    Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 8'h40, 32'h0, 0, d, w, low, first, relow);
    chk("mid_rst_old", 0, d, 32'hAAAA5555);
    chk("mid_rst_low", 0, 32'(low), 32'(L));

    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
